// File: rtl/dither_trig_ctrl.sv
// Periodic trigger controller for a dither generator.
// Applies pending configuration once per frame, issues a one-cycle trigger,
// waits out the frame period, and captures generator results with a
// sticky timeout when a frame ends without a result.
module dither_trig_ctrl #(
  parameter int unsigned P_WAIT_RST   = 9,
  parameter int unsigned P_AVG_RST    = 4,
  parameter int unsigned P_MIN_PERIOD = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_en,
  input  logic [31:0] i_period,
  input  logic        i_cfg_wr,
  input  logic [31:0] i_wait_cnt,
  input  logic [2:0]  i_avg_sel,
  input  logic        i_gen_done,
  input  logic [31:0] i_gen_data,
  output logic        o_trig,
  output logic [31:0] o_wait_cnt,
  output logic [2:0]  o_avg_sel,
  output logic [31:0] o_data,
  output logic        o_data_vld,
  output logic [15:0] o_frame_cnt,
  output logic        o_timeout,
  output logic        o_busy,
  output logic [1:0]  o_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_APPLY = 2'd1,
    S_TRIG  = 2'd2,
    S_WAIT  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] cnt;
  logic [31:0] eff_period;
  logic        wait_exit;
  logic        done_seen;
  logic        pend_flag;
  logic [31:0] pend_wait;
  logic [2:0]  pend_avg;

  // Load value leaves room for the TRIG and APPLY cycles so the
  // trigger-to-trigger spacing equals the clamped period exactly.
  always_comb begin
    eff_period = (i_period < 32'(P_MIN_PERIOD)) ? 32'(P_MIN_PERIOD) : i_period;
  end

  // Next-state decode and state-derived outputs.
  always_comb begin
    state_nxt = state;
    wait_exit = 1'b0;
    o_trig    = (state == S_TRIG);
    o_busy    = (state != S_IDLE);
    o_state   = state;
    case (state)
      S_IDLE:  if (i_en) state_nxt = S_APPLY;
      S_APPLY: state_nxt = S_TRIG;
      S_TRIG:  state_nxt = S_WAIT;
      S_WAIT: begin
        if (cnt == '0) begin
          wait_exit = 1'b1;
          state_nxt = i_en ? S_APPLY : S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Frame counter, result-seen tracking and sticky timeout.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt       <= '0;
      done_seen <= 1'b0;
      o_timeout <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (i_en) o_timeout <= 1'b0;
        S_TRIG: begin
          cnt       <= eff_period - 32'd3;
          done_seen <= 1'b0;
        end
        S_WAIT: begin
          if (cnt != '0) cnt <= cnt - 32'd1;
          if (i_gen_done) done_seen <= 1'b1;
          // A result arriving on the exit cycle itself still counts.
          if (wait_exit && !(done_seen || i_gen_done)) o_timeout <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Configuration staging: writes land in the pending slot, except a write
  // during APPLY which bypasses it and takes effect in the same frame.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_wait_cnt <= 32'(P_WAIT_RST);
      o_avg_sel  <= 3'(P_AVG_RST);
      pend_flag  <= 1'b0;
      pend_wait  <= '0;
      pend_avg   <= '0;
    end else if (state == S_APPLY) begin
      if (i_cfg_wr) begin
        o_wait_cnt <= i_wait_cnt;
        o_avg_sel  <= i_avg_sel;
      end else if (pend_flag) begin
        o_wait_cnt <= pend_wait;
        o_avg_sel  <= pend_avg;
      end
      pend_flag <= 1'b0;
    end else if (i_cfg_wr) begin
      pend_wait <= i_wait_cnt;
      pend_avg  <= i_avg_sel;
      pend_flag <= 1'b1;
    end
  end

  // Result capture and frame counting, independent of FSM state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_data      <= '0;
      o_data_vld  <= 1'b0;
      o_frame_cnt <= '0;
    end else begin
      o_data_vld <= i_gen_done;
      if (i_gen_done) begin
        o_data      <= i_gen_data;
        o_frame_cnt <= o_frame_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_dither_trig_ctrl.sv
// Self-checking bench for dither_trig_ctrl: directed vector table,
// trigger-spacing and counter-wrap sequences, and randomized stimulus
// against a frame-position reference model.
module tb_dither_trig_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [31:0] period = 32'd100;
  logic        cfg_wr = 1'b0;
  logic [31:0] wait_cnt = '0;
  logic [2:0]  avg_sel = '0;
  logic        gen_done = 1'b0;
  logic [31:0] gen_data = '0;
  logic        o_trig;
  logic [31:0] o_wait_cnt;
  logic [2:0]  o_avg_sel;
  logic [31:0] o_data;
  logic        o_data_vld;
  logic [15:0] o_frame_cnt;
  logic        o_timeout;
  logic        o_busy;
  logic [1:0]  o_state;

  always #5 clk = ~clk;

  dither_trig_ctrl #(
    .P_WAIT_RST  (9),
    .P_AVG_RST   (4),
    .P_MIN_PERIOD(4)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_en       (en),
    .i_period   (period),
    .i_cfg_wr   (cfg_wr),
    .i_wait_cnt (wait_cnt),
    .i_avg_sel  (avg_sel),
    .i_gen_done (gen_done),
    .i_gen_data (gen_data),
    .o_trig     (o_trig),
    .o_wait_cnt (o_wait_cnt),
    .o_avg_sel  (o_avg_sel),
    .o_data     (o_data),
    .o_data_vld (o_data_vld),
    .o_frame_cnt(o_frame_cnt),
    .o_timeout  (o_timeout),
    .o_busy     (o_busy),
    .o_state    (o_state)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        rst, en;
    logic [31:0] period;
    logic        cfg;
    logic [31:0] wc;
    logic [2:0]  av;
    logic        gd;
    logic [31:0] gdat;
    logic [1:0]  e_state;
    logic [31:0] e_wait;
    logic [2:0]  e_avg;
    logic        e_to, e_vld;
    logic [31:0] e_data;
    logic [15:0] e_fcnt;
  } vec_t;

  vec_t tbl[18];

  // Reference model: frame position 0=apply, 1=trigger, 2..len-1=waiting.
  bit          m_idle;
  int          m_pos, m_len;
  bit          m_seen, m_to, m_vld, m_pf;
  logic [31:0] m_wait, m_pw, m_data;
  logic [2:0]  m_avg, m_pa;
  int          m_fcnt;

  task automatic model_reset();
    m_idle = 1; m_pos = 0; m_len = 4; m_seen = 0; m_to = 0; m_vld = 0;
    m_pf = 0; m_wait = 9; m_avg = 4; m_pw = 0; m_pa = 0; m_data = 0; m_fcnt = 0;
  endtask

  task automatic model_step();
    if (rst) begin
      model_reset();
    end else begin
      m_vld = gen_done;
      if (gen_done) begin
        m_data = gen_data;
        m_fcnt = (m_fcnt + 1) % 65536;
      end
      if (!m_idle && m_pos == 0) begin
        if (cfg_wr) begin m_wait = wait_cnt; m_avg = avg_sel; end
        else if (m_pf) begin m_wait = m_pw; m_avg = m_pa; end
        m_pf = 0;
      end else if (cfg_wr) begin
        m_pw = wait_cnt; m_pa = avg_sel; m_pf = 1;
      end
      if (m_idle) begin
        if (en) begin m_idle = 0; m_pos = 0; m_to = 0; end
      end else if (m_pos == 0) begin
        m_pos = 1;
      end else if (m_pos == 1) begin
        m_len  = (period < 4) ? 4 : int'(period);
        m_seen = 0;
        m_pos  = 2;
      end else begin
        if (gen_done) m_seen = 1;
        if (m_pos == m_len - 1) begin
          if (!m_seen) m_to = 1;
          if (en) m_pos = 0; else m_idle = 1;
        end else begin
          m_pos++;
        end
      end
    end
  endtask

  function automatic logic [1:0] model_state();
    if (m_idle) return 2'd0;
    if (m_pos == 0) return 2'd1;
    if (m_pos == 1) return 2'd2;
    return 2'd3;
  endfunction

  task automatic spacing(input logic [31:0] per, input int n, input int cyc);
    rst = 1; en = 0; cfg_wr = 0; gen_done = 0;
    step();
    rst = 0; en = 1; period = per;
    for (int k = 1; k <= cyc; k++) begin
      step();
      chk("trig_spacing", 32'(o_trig), 32'(k >= 2 && (k - 2) % n == 0));
    end
  endtask

  initial begin
    //           rst en per  cfg wc  av gd gdat          st wait avg to vld data          fcnt
    tbl[0]  = '{1, 0, 100, 0, 0,  0, 0, 32'h0,         0, 9,  4,  0, 0, 32'h0,         16'd0};
    tbl[1]  = '{0, 1, 2,   0, 0,  0, 0, 32'h0,         1, 9,  4,  0, 0, 32'h0,         16'd0};
    tbl[2]  = '{0, 1, 2,   1, 20, 2, 0, 32'h0,         2, 20, 2,  0, 0, 32'h0,         16'd0};
    tbl[3]  = '{0, 1, 2,   0, 0,  0, 0, 32'h0,         3, 20, 2,  0, 0, 32'h0,         16'd0};
    tbl[4]  = '{0, 1, 2,   0, 0,  0, 1, 32'hFFFFF7CC,  3, 20, 2,  0, 1, 32'hFFFFF7CC,  16'd1};
    tbl[5]  = '{0, 1, 2,   1, 33, 5, 0, 32'h0,         1, 20, 2,  0, 0, 32'hFFFFF7CC,  16'd1};
    tbl[6]  = '{0, 1, 2,   0, 0,  0, 0, 32'h0,         2, 33, 5,  0, 0, 32'hFFFFF7CC,  16'd1};
    tbl[7]  = '{0, 0, 0,   0, 0,  0, 0, 32'h0,         3, 33, 5,  0, 0, 32'hFFFFF7CC,  16'd1};
    tbl[8]  = '{0, 0, 0,   0, 0,  0, 0, 32'h0,         3, 33, 5,  0, 0, 32'hFFFFF7CC,  16'd1};
    tbl[9]  = '{0, 0, 0,   0, 0,  0, 0, 32'h0,         0, 33, 5,  1, 0, 32'hFFFFF7CC,  16'd1};
    tbl[10] = '{0, 0, 0,   0, 0,  0, 0, 32'h0,         0, 33, 5,  1, 0, 32'hFFFFF7CC,  16'd1};
    tbl[11] = '{0, 1, 0,   0, 0,  0, 0, 32'h0,         1, 33, 5,  0, 0, 32'hFFFFF7CC,  16'd1};
    tbl[12] = '{0, 1, 100, 0, 0,  0, 0, 32'h0,         2, 33, 5,  0, 0, 32'hFFFFF7CC,  16'd1};
    tbl[13] = '{0, 1, 100, 0, 0,  0, 0, 32'h0,         3, 33, 5,  0, 0, 32'hFFFFF7CC,  16'd1};
    tbl[14] = '{1, 1, 100, 1, 77, 7, 1, 32'h1234,      0, 9,  4,  0, 0, 32'h0,         16'd0};
    tbl[15] = '{0, 0, 100, 0, 0,  0, 0, 32'h0,         0, 9,  4,  0, 0, 32'h0,         16'd0};
    tbl[16] = '{0, 1, 100, 0, 0,  0, 0, 32'h0,         1, 9,  4,  0, 0, 32'h0,         16'd0};
    tbl[17] = '{0, 1, 100, 0, 0,  0, 0, 32'h0,         2, 9,  4,  0, 0, 32'h0,         16'd0};

    #2;
    for (int i = 0; i < 18; i++) begin
      rst = tbl[i].rst; en = tbl[i].en; period = tbl[i].period;
      cfg_wr = tbl[i].cfg; wait_cnt = tbl[i].wc; avg_sel = tbl[i].av;
      gen_done = tbl[i].gd; gen_data = tbl[i].gdat;
      step();
      chk($sformatf("vec%0d_state", i), 32'(o_state), 32'(tbl[i].e_state));
      chk($sformatf("vec%0d_trig", i), 32'(o_trig), 32'(tbl[i].e_state == 2'd2));
      chk($sformatf("vec%0d_busy", i), 32'(o_busy), 32'(tbl[i].e_state != 2'd0));
      chk($sformatf("vec%0d_wait", i), o_wait_cnt, tbl[i].e_wait);
      chk($sformatf("vec%0d_avg", i), 32'(o_avg_sel), 32'(tbl[i].e_avg));
      chk($sformatf("vec%0d_timeout", i), 32'(o_timeout), 32'(tbl[i].e_to));
      chk($sformatf("vec%0d_vld", i), 32'(o_data_vld), 32'(tbl[i].e_vld));
      chk($sformatf("vec%0d_data", i), o_data, tbl[i].e_data);
      chk($sformatf("vec%0d_fcnt", i), 32'(o_frame_cnt), 32'(tbl[i].e_fcnt));
    end
    cfg_wr = 0; gen_done = 0;

    // Trigger spacing: nominal period and clamped short periods.
    spacing(32'd100, 100, 210);
    spacing(32'd2, 4, 30);
    spacing(32'd0, 4, 30);
    spacing(32'd5, 5, 30);

    // Frame counter wrap over 65536 strobes while idle.
    rst = 1; en = 0; step();
    rst = 0; gen_done = 1;
    for (int k = 1; k <= 65536; k++) begin
      gen_data = 32'(k) ^ 32'hA5A5_0000;
      step();
      if (k == 1) chk("wrap_vld", 32'(o_data_vld), 32'd1);
      if (k == 65535) chk("wrap_fcnt_max", 32'(o_frame_cnt), 32'hFFFF);
      if (k == 65536) begin
        chk("wrap_fcnt_zero", 32'(o_frame_cnt), 32'd0);
        chk("wrap_data", o_data, 32'(k) ^ 32'hA5A5_0000);
        chk("wrap_idle", 32'(o_state), 32'd0);
      end
    end
    gen_done = 0;

    // Randomized run against the reference model.
    rst = 1; model_step(); step();
    for (int c = 0; c < 4000; c++) begin
      rst      = ($urandom_range(0, 299) == 0);
      en       = ($urandom_range(0, 9) != 0);
      period   = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(0, 30)) : 32'($urandom_range(0, 8));
      cfg_wr   = ($urandom_range(0, 9) == 0);
      wait_cnt = $urandom;
      avg_sel  = 3'($urandom);
      gen_done = ($urandom_range(0, 9) < 2);
      gen_data = $urandom;
      model_step();
      step();
      chk("rnd_state", 32'(o_state), 32'(model_state()));
      chk("rnd_trig", 32'(o_trig), 32'(model_state() == 2'd2));
      chk("rnd_busy", 32'(o_busy), 32'(!m_idle));
      chk("rnd_wait", o_wait_cnt, m_wait);
      chk("rnd_avg", 32'(o_avg_sel), 32'(m_avg));
      chk("rnd_data", o_data, m_data);
      chk("rnd_vld", 32'(o_data_vld), 32'(m_vld));
      chk("rnd_fcnt", 32'(o_frame_cnt), 32'(m_fcnt));
      chk("rnd_timeout", 32'(o_timeout), 32'(m_to));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
